pci_initiator_ctrl: RTL and testbench

//  Bus-master (initiator) front end for one PCI device on the shared bus. It

---
 rtl/pci_pkg.sv | 17 +
 rtl/pci_devsel_timer.sv | 48 ++++
 rtl/pci_initiator_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_pci_initiator_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pci_pkg.sv
// Shared constants for the PCI initiator: C/BE command codes, byte-enable
// patterns and the controller state encoding.
package pci_pkg;

  localparam logic [3:0] PCI_MEM_RD = 4'b0110;
  localparam logic [3:0] PCI_MEM_WR = 4'b0111;
  localparam logic [3:0] BE_ALL     = 4'b0000;
  localparam logic [3:0] CBE_IDLE   = 4'b1111;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_REQST  = 3'd1;
  localparam logic [2:0] ST_ADDR   = 3'd2;
  localparam logic [2:0] ST_DATA   = 3'd3;
  localparam logic [2:0] ST_MABORT = 3'd4;
  localparam logic [2:0] ST_TURN   = 3'd5;

endpackage

// File: rtl/pci_devsel_timer.sv
// Counts data-phase clocks with DEVSEL deasserted after the address phase and
// flags master abort once DEVSEL_TIMEOUT such clocks have elapsed unclaimed.
module pci_devsel_timer #(
  parameter int DEVSEL_TIMEOUT = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic run_i,
  input  logic devsel_n_i,
  output logic expire_o
);

  localparam int TW = $clog2(DEVSEL_TIMEOUT + 1);
  localparam logic [TW-1:0] LAST = TW'(DEVSEL_TIMEOUT - 1);

  logic [TW-1:0] cnt_q, cnt_d;
  logic          armed_q, armed_d;

  // Once a target claims the transaction the timer is disarmed for the rest of it.
  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q;
    if (load_i) begin
      cnt_d   = '0;
      armed_d = 1'b1;
    end else if (run_i && armed_q) begin
      if (!devsel_n_i) begin
        armed_d = 1'b0;
      end else if (cnt_q != LAST) begin
        cnt_d = cnt_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

  assign expire_o = run_i && armed_q && devsel_n_i && (cnt_q == LAST);

endmodule

// File: rtl/pci_initiator_ctrl.sv
// PCI bus-master front end: requests the bus, runs one address phase and a
// burst of data phases with the IRDY/TRDY/DEVSEL handshake, then turns around.
module pci_initiator_ctrl
  import pci_pkg::*;
#(
  parameter int MAX_BURST      = 4,
  parameter int CNT_W          = 3,
  parameter int DEVSEL_TIMEOUT = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       cmd,
  input  logic [31:0]      addr,
  input  logic [CNT_W-1:0] num_words,
  input  logic [31:0]      wr_data,
  output logic             wr_data_rd,
  output logic [31:0]      rd_data,
  output logic             rd_valid,
  output logic             REQ,
  input  logic             GNT,
  output logic             FRAME,
  output logic             IRDY,
  input  logic             FRAME_in,
  input  logic             IRDY_in,
  input  logic             TRDY,
  input  logic             DEVSEL,
  output logic [31:0]      ad_out,
  output logic             ad_oe,
  input  logic [31:0]      ad_in,
  output logic [3:0]       cbe_out,
  output logic             busy,
  output logic             done,
  output logic             abort
);

  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  logic [2:0]       state_q, state_d;
  logic [3:0]       cmd_q, cmd_d;
  logic [31:0]      addr_q, addr_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [31:0]      rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             wr_data_rd_q, wr_data_rd_d;
  logic             done_q, done_d;
  logic             abort_q, abort_d;

  logic is_wr;
  logic xfer;
  logic expire;

  function automatic logic [CNT_W-1:0] clamp_words(input logic [CNT_W-1:0] n);
    if (n > BURST_MAX) return BURST_MAX;
    return n;
  endfunction

  assign is_wr = (cmd_q == PCI_MEM_WR);
  // IRDY is always asserted in DATA, so a transfer needs only the target side.
  assign xfer  = (state_q == ST_DATA) && !TRDY && !DEVSEL;

  pci_devsel_timer #(
    .DEVSEL_TIMEOUT(DEVSEL_TIMEOUT)
  ) u_devsel_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (state_q == ST_ADDR),
    .run_i     (state_q == ST_DATA),
    .devsel_n_i(DEVSEL),
    .expire_o  (expire)
  );

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    addr_d       = addr_q;
    remaining_d  = remaining_q;
    rd_data_d    = rd_data_q;
    rd_valid_d   = 1'b0;
    wr_data_rd_d = 1'b0;
    done_d       = 1'b0;
    abort_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && (num_words != '0)) begin
          state_d     = ST_REQST;
          cmd_d       = cmd;
          addr_d      = addr;
          remaining_d = clamp_words(num_words);
        end
      end
      ST_REQST: begin
        // A grant is only usable once the previous owner has left the bus.
        if (!GNT && FRAME_in && IRDY_in) state_d = ST_ADDR;
      end
      ST_ADDR: state_d = ST_DATA;
      ST_DATA: begin
        if (xfer) begin
          remaining_d = remaining_q - ONE;
          if (is_wr) begin
            wr_data_rd_d = 1'b1;
          end else begin
            rd_valid_d = 1'b1;
            rd_data_d  = ad_in;
          end
          if (remaining_q == ONE) begin
            state_d = ST_TURN;
            done_d  = 1'b1;
          end
        end else if (expire) begin
          state_d = ST_MABORT;
        end
      end
      ST_MABORT: begin
        state_d = ST_TURN;
        abort_d = 1'b1;
      end
      ST_TURN: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      remaining_q  <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      wr_data_rd_q <= 1'b0;
      done_q       <= 1'b0;
      abort_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      wr_data_rd_q <= wr_data_rd_d;
      done_q       <= done_d;
      abort_q      <= abort_d;
    end
  end

  always_ff @(posedge clk) begin
    cmd_q  <= cmd_d;
    addr_q <= addr_d;
  end

  // Bus-facing values decode straight from state so reset releases the bus on its edge.
  always_comb begin
    REQ     = (state_q != ST_REQST);
    FRAME   = 1'b1;
    IRDY    = 1'b1;
    ad_oe   = 1'b0;
    ad_out  = '0;
    cbe_out = CBE_IDLE;
    case (state_q)
      ST_ADDR: begin
        FRAME   = 1'b0;
        ad_oe   = 1'b1;
        ad_out  = addr_q;
        cbe_out = cmd_q;
      end
      ST_DATA: begin
        FRAME   = (remaining_q <= ONE);
        IRDY    = 1'b0;
        cbe_out = BE_ALL;
        if (is_wr) begin
          ad_oe  = 1'b1;
          ad_out = wr_data;
        end
      end
      ST_MABORT: begin
        IRDY    = 1'b0;
        cbe_out = BE_ALL;
      end
      default: ;
    endcase
  end

  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign abort      = abort_q;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;
  assign wr_data_rd = wr_data_rd_q;

endmodule

// File: tb/tb_pci_initiator_ctrl.sv
// Directed bench for pci_initiator_ctrl: write, read burst with waits, busy bus,
// master abort, mid-burst reset, ignored starts and burst clamping.
module tb_pci_initiator_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  cmd;
  logic [31:0] addr;
  logic [2:0]  num_words;
  logic [31:0] wr_data;
  logic        wr_data_rd;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        REQ;
  logic        GNT;
  logic        FRAME;
  logic        IRDY;
  logic        FRAME_in;
  logic        IRDY_in;
  logic        TRDY;
  logic        DEVSEL;
  logic [31:0] ad_out;
  logic        ad_oe;
  logic [31:0] ad_in;
  logic [3:0]  cbe_out;
  logic        busy;
  logic        done;
  logic        abort;

  int n_checks = 0;
  int n_errors = 0;

  pci_initiator_ctrl #(
    .MAX_BURST(4),
    .CNT_W(3),
    .DEVSEL_TIMEOUT(5)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cmd       (cmd),
    .addr      (addr),
    .num_words (num_words),
    .wr_data   (wr_data),
    .wr_data_rd(wr_data_rd),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .REQ       (REQ),
    .GNT       (GNT),
    .FRAME     (FRAME),
    .IRDY      (IRDY),
    .FRAME_in  (FRAME_in),
    .IRDY_in   (IRDY_in),
    .TRDY      (TRDY),
    .DEVSEL    (DEVSEL),
    .ad_out    (ad_out),
    .ad_oe     (ad_oe),
    .ad_in     (ad_in),
    .cbe_out   (cbe_out),
    .busy      (busy),
    .done      (done),
    .abort     (abort)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_REQ"},      32'(REQ),        32'h1);
    chk({tag, "_FRAME"},    32'(FRAME),      32'h1);
    chk({tag, "_IRDY"},     32'(IRDY),       32'h1);
    chk({tag, "_ad_oe"},    32'(ad_oe),      32'h0);
    chk({tag, "_ad_out"},   ad_out,          32'h0);
    chk({tag, "_cbe"},      32'(cbe_out),    32'hF);
    chk({tag, "_busy"},     32'(busy),       32'h0);
    chk({tag, "_done"},     32'(done),       32'h0);
    chk({tag, "_abort"},    32'(abort),      32'h0);
    chk({tag, "_rd_valid"}, 32'(rd_valid),   32'h0);
    chk({tag, "_wr_rd"},    32'(wr_data_rd), 32'h0);
    chk({tag, "_rd_data"},  rd_data,         32'h0);
  endtask

  task automatic release_target();
    GNT    = 1'b1;
    TRDY   = 1'b1;
    DEVSEL = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; cmd = 4'h0; addr = 32'h0; num_words = 3'd0;
    wr_data = 32'h0; GNT = 1'b1; FRAME_in = 1'b1; IRDY_in = 1'b1;
    TRDY = 1'b1; DEVSEL = 1'b1; ad_in = 32'h0;
    tick();
    tick();
    chk_reset_vals("rst");
    rst_n = 1'b1;
    tick();

    // single-word write
    cmd = 4'b0111; addr = 32'h1000_0000; num_words = 3'd1; wr_data = 32'hA5A5_0001;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_req_low", 32'(REQ), 32'h0);
    chk("t1_busy", 32'(busy), 32'h1);
    GNT = 1'b0;
    tick();
    chk("t1_addr_frame", 32'(FRAME), 32'h0);
    chk("t1_addr_oe", 32'(ad_oe), 32'h1);
    chk("t1_addr_ad", ad_out, 32'h1000_0000);
    chk("t1_addr_cbe", 32'(cbe_out), 32'h7);
    chk("t1_addr_req", 32'(REQ), 32'h1);
    TRDY = 1'b0; DEVSEL = 1'b0;
    tick();
    chk("t1_data_frame", 32'(FRAME), 32'h1);
    chk("t1_data_irdy", 32'(IRDY), 32'h0);
    chk("t1_data_ad", ad_out, 32'hA5A5_0001);
    chk("t1_data_oe", 32'(ad_oe), 32'h1);
    chk("t1_data_cbe", 32'(cbe_out), 32'h0);
    tick();
    chk("t1_done", 32'(done), 32'h1);
    chk("t1_wr_rd", 32'(wr_data_rd), 32'h1);
    chk("t1_turn_irdy", 32'(IRDY), 32'h1);
    chk("t1_turn_cbe", 32'(cbe_out), 32'hF);
    chk("t1_turn_oe", 32'(ad_oe), 32'h0);
    release_target();
    tick();
    chk("t1_done_clr", 32'(done), 32'h0);
    chk("t1_wr_rd_clr", 32'(wr_data_rd), 32'h0);
    chk("t1_idle_busy", 32'(busy), 32'h0);

    // four-word read, two wait states on word 2
    cmd = 4'b0110; addr = 32'h2000_0000; num_words = 3'd4; start = 1'b1;
    tick();
    start = 1'b0; GNT = 1'b0;
    tick();
    chk("t2_addr_ad", ad_out, 32'h2000_0000);
    chk("t2_addr_cbe", 32'(cbe_out), 32'h6);
    DEVSEL = 1'b0; TRDY = 1'b0; ad_in = 32'hD000_0000;
    tick();
    chk("t2_p1_frame", 32'(FRAME), 32'h0);
    chk("t2_p1_irdy", 32'(IRDY), 32'h0);
    chk("t2_p1_oe", 32'(ad_oe), 32'h0);
    tick();
    chk("t2_rv0", 32'(rd_valid), 32'h1);
    chk("t2_rd0", rd_data, 32'hD000_0000);
    chk("t2_p2_frame", 32'(FRAME), 32'h0);
    TRDY = 1'b1; ad_in = 32'hDEAD_BEEF;
    tick();
    chk("t2_w1_rv", 32'(rd_valid), 32'h0);
    chk("t2_w1_irdy", 32'(IRDY), 32'h0);
    tick();
    chk("t2_w2_irdy", 32'(IRDY), 32'h0);
    chk("t2_w2_rd", rd_data, 32'hD000_0000);
    TRDY = 1'b0; ad_in = 32'hD000_0001;
    tick();
    chk("t2_rv1", 32'(rd_valid), 32'h1);
    chk("t2_rd1", rd_data, 32'hD000_0001);
    chk("t2_p3_frame", 32'(FRAME), 32'h0);
    ad_in = 32'hD000_0002;
    tick();
    chk("t2_rd2", rd_data, 32'hD000_0002);
    chk("t2_p4_frame", 32'(FRAME), 32'h1);
    chk("t2_p4_irdy", 32'(IRDY), 32'h0);
    ad_in = 32'hD000_0003;
    tick();
    chk("t2_rv3", 32'(rd_valid), 32'h1);
    chk("t2_rd3", rd_data, 32'hD000_0003);
    chk("t2_done", 32'(done), 32'h1);
    release_target();
    tick();
    chk("t2_idle_busy", 32'(busy), 32'h0);

    // grant withheld, then granted while another master still owns the bus
    cmd = 4'b0111; addr = 32'h3000_0000; num_words = 3'd2; wr_data = 32'h3333_0000;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("t3_nogrant_req", 32'(REQ), 32'h0);
    GNT = 1'b0; FRAME_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_busybus_req", 32'(REQ), 32'h0);
      chk("t3_busybus_oe", 32'(ad_oe), 32'h0);
    end
    FRAME_in = 1'b1;
    tick();
    chk("t3_addr_frame", 32'(FRAME), 32'h0);
    chk("t3_addr_ad", ad_out, 32'h3000_0000);
    TRDY = 1'b0; DEVSEL = 1'b0;
    tick();
    chk("t3_p1_frame", 32'(FRAME), 32'h0);
    chk("t3_p1_ad", ad_out, 32'h3333_0000);
    GNT = 1'b1;
    tick();
    chk("t3_wr_rd0", 32'(wr_data_rd), 32'h1);
    chk("t3_p2_frame", 32'(FRAME), 32'h1);
    wr_data = 32'h3333_0001;
    #1;
    chk("t3_p2_ad", ad_out, 32'h3333_0001);
    tick();
    chk("t3_done", 32'(done), 32'h1);
    chk("t3_wr_rd1", 32'(wr_data_rd), 32'h1);
    release_target();
    tick();
    chk("t3_idle_busy", 32'(busy), 32'h0);

    // no target claims the cycle
    cmd = 4'b0110; addr = 32'h4000_0000; num_words = 3'd2; start = 1'b1;
    tick();
    start = 1'b0; GNT = 1'b0;
    tick();
    TRDY = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_wait_irdy", 32'(IRDY), 32'h0);
      chk("t4_wait_frame", 32'(FRAME), 32'h0);
      chk("t4_wait_rv", 32'(rd_valid), 32'h0);
    end
    tick();
    chk("t4_mab_frame", 32'(FRAME), 32'h1);
    chk("t4_mab_irdy", 32'(IRDY), 32'h0);
    chk("t4_mab_oe", 32'(ad_oe), 32'h0);
    chk("t4_mab_abort", 32'(abort), 32'h0);
    tick();
    chk("t4_abort", 32'(abort), 32'h1);
    chk("t4_no_done", 32'(done), 32'h0);
    chk("t4_no_rv", 32'(rd_valid), 32'h0);
    chk("t4_turn_irdy", 32'(IRDY), 32'h1);
    release_target();
    tick();
    chk("t4_abort_clr", 32'(abort), 32'h0);
    chk("t4_idle_busy", 32'(busy), 32'h0);

    // reset in the middle of a write burst
    cmd = 4'b0111; addr = 32'h5000_0000; num_words = 3'd4; wr_data = 32'h5555_AAAA;
    start = 1'b1;
    tick();
    start = 1'b0; GNT = 1'b0;
    tick();
    TRDY = 1'b0; DEVSEL = 1'b0;
    tick();
    tick();
    chk("t5_wr_rd_pre", 32'(wr_data_rd), 32'h1);
    rst_n = 1'b0;
    tick();
    chk_reset_vals("t5_rst");
    rst_n = 1'b1;
    release_target();
    cmd = 4'b0110; addr = 32'h5555_0000; num_words = 3'd1; start = 1'b1;
    tick();
    chk("t5_req", 32'(REQ), 32'h0);
    start = 1'b0; GNT = 1'b0;
    tick();
    chk("t5_addr_ad", ad_out, 32'h5555_0000);
    TRDY = 1'b0; DEVSEL = 1'b0; ad_in = 32'h1234_5678;
    tick();
    chk("t5_frame", 32'(FRAME), 32'h1);
    tick();
    chk("t5_rv", 32'(rd_valid), 32'h1);
    chk("t5_rd", rd_data, 32'h1234_5678);
    chk("t5_done", 32'(done), 32'h1);
    release_target();
    tick();

    // zero-length start, start while busy, burst length clamp
    num_words = 3'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("t6_zero_req", 32'(REQ), 32'h1);
    chk("t6_zero_busy", 32'(busy), 32'h0);
    cmd = 4'b0111; addr = 32'h6000_0000; num_words = 3'd7; wr_data = 32'h6666_6666;
    start = 1'b1;
    tick();
    cmd = 4'b0110; addr = 32'h6666_0000; num_words = 3'd1;
    tick();
    chk("t6_busy_req", 32'(REQ), 32'h0);
    chk("t6_busy_busy", 32'(busy), 32'h1);
    start = 1'b0; GNT = 1'b0;
    tick();
    chk("t6_addr_ad", ad_out, 32'h6000_0000);
    chk("t6_addr_cbe", 32'(cbe_out), 32'h7);
    TRDY = 1'b0; DEVSEL = 1'b0;
    tick();
    chk("t6_p1_frame", 32'(FRAME), 32'h0);
    for (int i = 0; i < 3; i++) begin
      logic exp_frame;
      exp_frame = (i == 2);
      tick();
      chk("t6_wr_rd", 32'(wr_data_rd), 32'h1);
      chk("t6_no_done", 32'(done), 32'h0);
      chk("t6_frame", 32'(FRAME), 32'(exp_frame));
    end
    tick();
    chk("t6_done", 32'(done), 32'h1);
    release_target();
    tick();
    chk("t6_idle_busy", 32'(busy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
